demux_reg_1_n: RTL and testbench

- Parametrised, registered successor of the combinational 1:32 demultiplexer.
- Routes one DATA_WIDTH word to one of NUM_CHANNELS channels, or to all channels (broadcast).
- Adds a one-entry valid/ready pipeline stage, a one-hot per-channel valid bus, a selectable hold/clear output mode and an optional hardwired-zero channel 0.
- Sits between the writeback stage and the register file / peripheral write ports of the RISC-V core.

---
 rtl/demux_pkg.sv | 35 +++
 rtl/demux_chan_reg.sv | 53 +++++
 rtl/demux_reg_1_n.sv | 133 +++++++++++++
 tb/tb_demux_reg_1_n.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the registered 1:N demultiplexer.
//   DEMUX_MODE_CLEAR / DEMUX_MODE_HOLD : output mode selectors
//   MAX_CHANNELS / MAX_SEL_WIDTH       : largest supported configuration
//   chan_vec_t                         : channel bit-vector at maximum width
//   sel_onehot(sel, n)                 : n-bit one-hot decode of sel, or 0
//                                        when sel >= n
// ---------------------------------------------------------------------------
package demux_pkg;

   localparam int DEMUX_MODE_CLEAR = 0;
   localparam int DEMUX_MODE_HOLD  = 1;

   localparam int MAX_CHANNELS  = 64;
   localparam int MAX_SEL_WIDTH = 8;

   typedef logic [MAX_CHANNELS-1:0] chan_vec_t;

   // Decodes at maximum width so one function serves every configuration.
   // Callers keep the low n bits. An out-of-range selector yields all zeros,
   // which is how the top level tells a dropped transfer apart from a write.
   function automatic chan_vec_t sel_onehot(input logic [MAX_SEL_WIDTH-1:0] sel,
                                            input int n);
      chan_vec_t v;
      v = '0;
      for (int i = 0; i < MAX_CHANNELS; i++) begin
         if ((i < n) && (sel == MAX_SEL_WIDTH'(i))) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// ---------------------------------------------------------------------------
// demux_chan_reg
// One channel of the registered demultiplexer: a data register with write
// and clear enables plus the channel's output gating.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, clears the register
//   wr_en  : load d on the next edge
//   clr_en : load 0 on the next edge (ignored when wr_en is high)
//   d      : word to load
//   valid  : this channel's valid bit, used for clear-mode gating
//   q      : channel data as seen by the consumer
// Parameters:
//   HOLD_MODE  : DEMUX_MODE_CLEAR gates q with valid, DEMUX_MODE_HOLD does not
//   ZERO_FORCE : 1 makes this a hardwired-zero channel (x0 semantics)
// ---------------------------------------------------------------------------
import demux_pkg::*;

module demux_chan_reg #(
   parameter int DATA_WIDTH = 32,
   parameter int HOLD_MODE  = DEMUX_MODE_CLEAR,
   parameter bit ZERO_FORCE = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  clr_en,
   input  logic [DATA_WIDTH-1:0] d,
   input  logic                  valid,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] data_q;

   // A zero-forced channel never leaves 0. The register then reduces to a
   // constant and synthesis removes it, while the valid bit for this channel
   // is still managed normally by the top level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (ZERO_FORCE) begin
         data_q <= '0;
      end else if (wr_en) begin
         data_q <= d;
      end else if (clr_en) begin
         data_q <= '0;
      end
   end

   // In clear mode a channel only shows data while its transfer is pending,
   // so a consumer never sees a stale word on a channel that is not valid.
   assign q = ((HOLD_MODE == DEMUX_MODE_HOLD) || valid) ? data_q : '0;

endmodule

// File: rtl/demux_reg_1_n.sv
// ---------------------------------------------------------------------------
// demux_reg_1_n
// Registered 1:N demultiplexer with a one-entry valid/ready stage. It sits
// between writeback and the register file / peripheral write ports.
//   DEMUXREG_CLOCK_50       : rising-edge clock
//   DEMUXREG_RESET_InHigh   : asynchronous active-high reset
//   DEMUXREG_Data_InBUS     : input word
//   DEMUXREG_Selector_InBUS : target channel index
//   DEMUXREG_Broadcast_In   : 1 writes every channel, selector ignored
//   DEMUXREG_InValid        : input transfer valid
//   DEMUXREG_InReady        : stage can take a transfer this cycle
//   DEMUXREG_Data_OutBUS    : channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   DEMUXREG_Valid_OutBUS   : per-channel valid, one-hot or all ones
//   DEMUXREG_OutReady       : downstream takes the current output transfer
//   DEMUXREG_Err_Out        : one-cycle pulse after an out-of-range selector
// ---------------------------------------------------------------------------
import demux_pkg::*;

module demux_reg_1_n #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_CHANNELS = 32,
   parameter int SEL_WIDTH    = 5,
   parameter int HOLD_MODE    = DEMUX_MODE_CLEAR,
   parameter bit ZERO_CH0     = 1'b1
) (
   input  logic                               DEMUXREG_CLOCK_50,
   input  logic                               DEMUXREG_RESET_InHigh,
   input  logic [DATA_WIDTH-1:0]              DEMUXREG_Data_InBUS,
   input  logic [SEL_WIDTH-1:0]               DEMUXREG_Selector_InBUS,
   input  logic                               DEMUXREG_Broadcast_In,
   input  logic                               DEMUXREG_InValid,
   output logic                               DEMUXREG_InReady,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0] DEMUXREG_Data_OutBUS,
   output logic [NUM_CHANNELS-1:0]            DEMUXREG_Valid_OutBUS,
   input  logic                               DEMUXREG_OutReady,
   output logic                               DEMUXREG_Err_Out
);

   // Catch inconsistent configurations at elaboration rather than in silicon.
   if ((NUM_CHANNELS < 2) || (NUM_CHANNELS > MAX_CHANNELS)) begin : g_bad_channels
      $error("demux_reg_1_n: NUM_CHANNELS must be in 2..64");
   end
   if (SEL_WIDTH != $clog2(NUM_CHANNELS)) begin : g_bad_sel_width
      $error("demux_reg_1_n: SEL_WIDTH must equal clog2(NUM_CHANNELS)");
   end

   logic                    clk;
   logic                    rst;
   chan_vec_t               onehot_full;
   logic [NUM_CHANNELS-1:0] dec_vec;
   logic [NUM_CHANNELS-1:0] valid_q;
   logic                    in_range;
   logic                    in_ready;
   logic                    accept;
   logic                    load;
   logic                    err_q;

   assign clk = DEMUXREG_CLOCK_50;
   assign rst = DEMUXREG_RESET_InHigh;

   // Decode target channels. Broadcast overrides the selector entirely, so an
   // out-of-range selector is harmless when broadcasting.
   assign onehot_full = sel_onehot(MAX_SEL_WIDTH'(DEMUXREG_Selector_InBUS), NUM_CHANNELS);
   assign dec_vec     = DEMUXREG_Broadcast_In ? '1 : onehot_full[NUM_CHANNELS-1:0];

   // The decoder works at maximum width; bits above NUM_CHANNELS are always 0.
   if (NUM_CHANNELS < MAX_CHANNELS) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^onehot_full[MAX_CHANNELS-1:NUM_CHANNELS];
   end

   // An empty decode means an out-of-range selector. The transfer is still
   // consumed so the producer never stalls on a bad index.
   assign in_range = |dec_vec;

   // Single-entry stage without a skid buffer: we take a new word when the
   // output slot is empty or is being drained on this same edge.
   assign in_ready = !(|valid_q) | DEMUXREG_OutReady;
   assign accept   = DEMUXREG_InValid & in_ready;
   assign load     = accept & in_range;

   // Valid pattern. A good transfer replaces the slot contents. Otherwise, if
   // the slot could be drained this cycle, it empties. When in_ready is low the
   // slot is stalled and holds its pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (load) begin
         valid_q <= dec_vec;
      end else if (in_ready) begin
         valid_q <= '0;
      end
   end

   // The error flag is a registered pulse, so it lines up with the cycle in
   // which a good transfer would have appeared on the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= accept & ~in_range;
      end
   end

   // One register per channel. In clear mode, a good transfer also zeroes
   // every channel it does not target, so no stale word lingers in the array.
   for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
      logic wr_en;
      logic clr_en;

      assign wr_en  = load & dec_vec[k];
      assign clr_en = load & ~dec_vec[k] & (HOLD_MODE == DEMUX_MODE_CLEAR);

      demux_chan_reg #(
         .DATA_WIDTH (DATA_WIDTH),
         .HOLD_MODE  (HOLD_MODE),
         .ZERO_FORCE ((k == 0) && ZERO_CH0)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .wr_en  (wr_en),
         .clr_en (clr_en),
         .d      (DEMUXREG_Data_InBUS),
         .valid  (valid_q[k]),
         .q      (DEMUXREG_Data_OutBUS[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   assign DEMUXREG_InReady      = in_ready;
   assign DEMUXREG_Valid_OutBUS = valid_q;
   assign DEMUXREG_Err_Out      = err_q;

endmodule

// File: tb/tb_demux_reg_1_n.sv
// ---------------------------------------------------------------------------
// tb_demux_reg_1_n
// Directed bench for demux_reg_1_n. Three instances share one set of inputs:
//   dut      : 32 channels, clear mode, hardwired-zero channel 0
//   dut_hold : 32 channels, hold mode
//   dut_24   : 24 channels, so selectors 24..31 are out of range
// ---------------------------------------------------------------------------
module tb_demux_reg_1_n;

   logic        clk;
   logic        rst;
   logic [31:0] data_in;
   logic [4:0]  sel;
   logic        broadcast;
   logic        in_valid;
   logic        out_ready;

   logic          ready_a, ready_h, ready_24;
   logic [1023:0] data_a, data_h;
   logic [767:0]  data_24;
   logic [31:0]   valid_a, valid_h;
   logic [23:0]   valid_24;
   logic          err_a, err_h, err_24;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   demux_reg_1_n #(.NUM_CHANNELS(32), .SEL_WIDTH(5), .HOLD_MODE(0), .ZERO_CH0(1'b1)) dut (
      .DEMUXREG_CLOCK_50       (clk),
      .DEMUXREG_RESET_InHigh   (rst),
      .DEMUXREG_Data_InBUS     (data_in),
      .DEMUXREG_Selector_InBUS (sel),
      .DEMUXREG_Broadcast_In   (broadcast),
      .DEMUXREG_InValid        (in_valid),
      .DEMUXREG_InReady        (ready_a),
      .DEMUXREG_Data_OutBUS    (data_a),
      .DEMUXREG_Valid_OutBUS   (valid_a),
      .DEMUXREG_OutReady       (out_ready),
      .DEMUXREG_Err_Out        (err_a)
   );

   demux_reg_1_n #(.NUM_CHANNELS(32), .SEL_WIDTH(5), .HOLD_MODE(1), .ZERO_CH0(1'b1)) dut_hold (
      .DEMUXREG_CLOCK_50       (clk),
      .DEMUXREG_RESET_InHigh   (rst),
      .DEMUXREG_Data_InBUS     (data_in),
      .DEMUXREG_Selector_InBUS (sel),
      .DEMUXREG_Broadcast_In   (broadcast),
      .DEMUXREG_InValid        (in_valid),
      .DEMUXREG_InReady        (ready_h),
      .DEMUXREG_Data_OutBUS    (data_h),
      .DEMUXREG_Valid_OutBUS   (valid_h),
      .DEMUXREG_OutReady       (out_ready),
      .DEMUXREG_Err_Out        (err_h)
   );

   demux_reg_1_n #(.NUM_CHANNELS(24), .SEL_WIDTH(5), .HOLD_MODE(0), .ZERO_CH0(1'b1)) dut_24 (
      .DEMUXREG_CLOCK_50       (clk),
      .DEMUXREG_RESET_InHigh   (rst),
      .DEMUXREG_Data_InBUS     (data_in),
      .DEMUXREG_Selector_InBUS (sel),
      .DEMUXREG_Broadcast_In   (broadcast),
      .DEMUXREG_InValid        (in_valid),
      .DEMUXREG_InReady        (ready_24),
      .DEMUXREG_Data_OutBUS    (data_24),
      .DEMUXREG_Valid_OutBUS   (valid_24),
      .DEMUXREG_OutReady       (out_ready),
      .DEMUXREG_Err_Out        (err_24)
   );

   // 100 MHz style free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Channel slices of each instance's data bus
   function automatic logic [31:0] ch_a(input int k);
      return data_a[k*32 +: 32];
   endfunction

   function automatic logic [31:0] ch_h(input int k);
      return data_h[k*32 +: 32];
   endfunction

   // Single comparison point; every check goes through here
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle just after it
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      data_in   = '0;
      sel       = '0;
      broadcast = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;

      // Reset state
      #3;
      checkOutput("rst_valid", 64'(valid_a), 64'h0);
      checkOutput("rst_ready", 64'(ready_a), 64'h1);
      checkOutput("rst_err", 64'(err_24), 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rel_ready", 64'(ready_a), 64'h1);

      // Single write to channel 5
      in_valid = 1'b1; sel = 5'd5; data_in = 32'hDEADBEEF;
      applyStimulus();
      checkOutput("w5_valid", 64'(valid_a), 64'h0000_0020);
      for (int k = 0; k < 32; k++) begin
         checkOutput($sformatf("w5_ch%0d", k), 64'(ch_a(k)), (k == 5) ? 64'hDEADBEEF : 64'h0);
      end
      checkOutput("w5_valid24", 64'(valid_24), 64'h20);
      in_valid = 1'b0;
      applyStimulus();
      checkOutput("drain_valid", 64'(valid_a), 64'h0);
      checkOutput("drain_ch5", 64'(ch_a(5)), 64'h0);

      // Backpressure: channel 3 stalls, channel 4 waits
      out_ready = 1'b0; in_valid = 1'b1; sel = 5'd3; data_in = 32'h11;
      applyStimulus();
      checkOutput("bp_valid", 64'(valid_a), 64'h8);
      checkOutput("bp_ch3", 64'(ch_a(3)), 64'h11);
      checkOutput("bp_ready", 64'(ready_a), 64'h0);
      sel = 5'd4; data_in = 32'h22;
      for (int c = 0; c < 4; c++) begin
         applyStimulus();
         checkOutput($sformatf("hold%0d_valid", c), 64'(valid_a), 64'h8);
         checkOutput($sformatf("hold%0d_ch3", c), 64'(ch_a(3)), 64'h11);
         checkOutput($sformatf("hold%0d_ch4", c), 64'(ch_a(4)), 64'h0);
         checkOutput($sformatf("hold%0d_ready", c), 64'(ready_a), 64'h0);
      end
      out_ready = 1'b1;
      #1;
      checkOutput("or_ready", 64'(ready_a), 64'h1);
      applyStimulus();
      checkOutput("b2b_valid", 64'(valid_a), 64'h10);
      checkOutput("b2b_ch4", 64'(ch_a(4)), 64'h22);
      checkOutput("b2b_ch3", 64'(ch_a(3)), 64'h0);
      in_valid = 1'b0;
      applyStimulus();
      checkOutput("b2b_drain", 64'(valid_a), 64'h0);

      // Broadcast with hardwired-zero channel 0
      broadcast = 1'b1; in_valid = 1'b1; sel = 5'd30; data_in = 32'hA5A5A5A5;
      applyStimulus();
      checkOutput("bc_valid", 64'(valid_a), 64'hFFFF_FFFF);
      checkOutput("bc_valid24", 64'(valid_24), 64'hFF_FFFF);
      checkOutput("bc_err24", 64'(err_24), 64'h0);
      for (int k = 0; k < 32; k++) begin
         checkOutput($sformatf("bc_ch%0d", k), 64'(ch_a(k)), (k == 0) ? 64'h0 : 64'hA5A5A5A5);
      end
      broadcast = 1'b0; in_valid = 1'b0;
      applyStimulus();

      // Channel 0 and channel 31 back to back
      in_valid = 1'b1; sel = 5'd0; data_in = 32'h1234;
      applyStimulus();
      checkOutput("c0_valid", 64'(valid_a), 64'h1);
      checkOutput("c0_data", 64'(ch_a(0)), 64'h0);
      sel = 5'd31; data_in = 32'hCAFEF00D;
      applyStimulus();
      checkOutput("c31_valid", 64'(valid_a), 64'h8000_0000);
      checkOutput("c31_data", 64'(ch_a(31)), 64'hCAFEF00D);
      checkOutput("c31_err", 64'(err_a), 64'h0);
      checkOutput("c31_err24", 64'(err_24), 64'h1);
      in_valid = 1'b0;
      applyStimulus();
      checkOutput("c31_err24_end", 64'(err_24), 64'h0);

      // Hold mode keeps channel 7 after its valid bit drops; clear mode does not
      in_valid = 1'b1; sel = 5'd7; data_in = 32'h55;
      applyStimulus();
      checkOutput("h7_valid", 64'(valid_h), 64'h80);
      sel = 5'd9; data_in = 32'h66;
      applyStimulus();
      checkOutput("h9_valid", 64'(valid_h), 64'h200);
      checkOutput("h9_hold_ch7", 64'(ch_h(7)), 64'h55);
      checkOutput("h9_hold_ch9", 64'(ch_h(9)), 64'h66);
      checkOutput("h9_clr_ch7", 64'(ch_a(7)), 64'h0);
      checkOutput("h9_clr_ch9", 64'(ch_a(9)), 64'h66);
      in_valid = 1'b0;
      applyStimulus();
      checkOutput("hd_valid", 64'(valid_h), 64'h0);
      checkOutput("hd_hold_ch9", 64'(ch_h(9)), 64'h66);
      checkOutput("hd_clr_ch9", 64'(ch_a(9)), 64'h0);

      // Out-of-range selector on the 24-channel instance
      in_valid = 1'b1; sel = 5'd30; data_in = 32'h77;
      applyStimulus();
      checkOutput("oor_err24", 64'(err_24), 64'h1);
      checkOutput("oor_valid24", 64'(valid_24), 64'h0);
      checkOutput("oor_err32", 64'(err_a), 64'h0);
      checkOutput("oor_valid32", 64'(valid_a), 64'h4000_0000);
      in_valid = 1'b0;
      applyStimulus();
      checkOutput("oor_err24_end", 64'(err_24), 64'h0);

      // Asynchronous reset while a transfer is stalled
      out_ready = 1'b0; in_valid = 1'b1; sel = 5'd3; data_in = 32'h99;
      applyStimulus();
      in_valid = 1'b0;
      checkOutput("ar_pre_valid", 64'(valid_a), 64'h8);
      checkOutput("ar_pre_hold7", 64'(ch_h(7)), 64'h55);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("ar_valid", 64'(valid_a), 64'h0);
      checkOutput("ar_ch3", 64'(ch_a(3)), 64'h0);
      checkOutput("ar_hold7", 64'(ch_h(7)), 64'h0);
      checkOutput("ar_ready", 64'(ready_a), 64'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("ar_rel_ready", 64'(ready_a), 64'h1);
      applyStimulus();
      checkOutput("ar_idle_valid", 64'(valid_a), 64'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
